// File: rtl/nvme_ctrl_init.sv
// NVMe controller enable sequencer: reads CAP, optionally disables the controller
// (NVME_INIT_DISABLE_PHASE_EN), writes CC.EN=1 and polls CSTS until RDY, CFS or timeout.
module nvme_ctrl_init #(
    parameter logic [31:0] CC_CFG         = 32'h0046_0000,
    parameter int unsigned TO_UNIT_CYCLES = 1000,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    input  logic [31:0] reg_rd_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [63:0] cap
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        PH_CAPL     = 3'd0,
        PH_CAPH     = 3'd1,
        PH_DIS_WR   = 3'd2,
        PH_DIS_POLL = 3'd3,
        PH_ENA_WR   = 3'd4,
        PH_ENA_POLL = 3'd5
    } phase_t;

    localparam logic [15:0] ADDR_CAPL = 16'h0000;
    localparam logic [15:0] ADDR_CAPH = 16'h0004;
    localparam logic [15:0] ADDR_CC   = 16'h0014;
    localparam logic [15:0] ADDR_CSTS = 16'h001C;

    localparam logic [31:0] TO_UNIT  = 32'(TO_UNIT_CYCLES);
    localparam logic [31:0] GAP_N    = 32'(POLL_GAP);
    localparam logic [31:0] GAP_LAST = (GAP_N == 32'd0) ? 32'd0 : (GAP_N - 32'd1);
    // With no gap configured a failed poll re-reads CSTS immediately.
    localparam state_t      RETRY_ST = (GAP_N == 32'd0) ? S_RD_A : S_GAP;
    localparam logic [31:0] CC_ENA   = CC_CFG | 32'h0000_0001;

    state_t      state_r, state_s;
    phase_t      phase_r, phase_s;
    logic        accept_s;
    logic        timeout_s;
    logic [1:0]  fin_err_s;

    logic [31:0] cnt_r;
    logic [31:0] gap_r;
    logic [31:0] budget_r;

    logic [15:0] reg_addr_r,    reg_addr_s;
    logic [31:0] reg_wr_data_r, reg_wr_data_s;
    logic        reg_wr_en_r,   reg_wr_en_s;
    logic        busy_r,        busy_s;
    logic        done_r,        done_s;
    logic [1:0]  error_r,       error_s;
    logic [63:0] cap_r;

    function automatic logic [15:0] phase_addr(input phase_t ph);
        logic [15:0] a;
        case (ph)
            PH_CAPL:     a = ADDR_CAPL;
            PH_CAPH:     a = ADDR_CAPH;
            PH_DIS_WR:   a = ADDR_CC;
            PH_ENA_WR:   a = ADDR_CC;
            PH_DIS_POLL: a = ADDR_CSTS;
            PH_ENA_POLL: a = ADDR_CSTS;
            default:     a = 16'h0000;
        endcase
        return a;
    endfunction

    function automatic logic is_poll(input phase_t ph);
        return (ph == PH_DIS_POLL) || (ph == PH_ENA_POLL);
    endfunction

    // State and phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            phase_r <= PH_CAPL;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
        end
    end

    // Next-state and phase sequencing; poll decisions use the counter at the data sample.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        accept_s  = 1'b0;
        fin_err_s = 2'd0;
        timeout_s = (cnt_r >= budget_r);
        case (state_r)
            S_IDLE, S_FIN: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = S_RD_A;
                    phase_s  = PH_CAPL;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_RD_A: begin
                state_s = S_RD_D;
            end
            S_RD_D: begin
                case (phase_r)
                    PH_CAPL: begin
                        phase_s = PH_CAPH;
                        state_s = S_RD_A;
                    end
                    PH_CAPH: begin
`ifdef NVME_INIT_DISABLE_PHASE_EN
                        phase_s = PH_DIS_WR;
`else
                        phase_s = PH_ENA_WR;
`endif
                        state_s = S_WR;
                    end
`ifdef NVME_INIT_DISABLE_PHASE_EN
                    PH_DIS_POLL: begin
                        if (!reg_rd_data[0]) begin
                            phase_s = PH_ENA_WR;
                            state_s = S_WR;
                        end else if (timeout_s) begin
                            fin_err_s = 2'd3;
                            state_s   = S_FIN;
                        end else begin
                            state_s   = RETRY_ST;
                        end
                    end
`endif
                    PH_ENA_POLL: begin
                        if (reg_rd_data[1]) begin
                            fin_err_s = 2'd2;
                            state_s   = S_FIN;
                        end else if (reg_rd_data[0]) begin
                            fin_err_s = 2'd0;
                            state_s   = S_FIN;
                        end else if (timeout_s) begin
                            fin_err_s = 2'd1;
                            state_s   = S_FIN;
                        end else begin
                            state_s   = RETRY_ST;
                        end
                    end
                    default: begin
                        state_s = S_IDLE;
                    end
                endcase
            end
            S_WR: begin
                state_s = S_RD_A;
                if (phase_r == PH_DIS_WR) begin
                    phase_s = PH_DIS_POLL;
                end else begin
                    phase_s = PH_ENA_POLL;
                end
            end
            S_GAP: begin
                if (gap_r >= GAP_LAST) begin
                    state_s = S_RD_A;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        reg_addr_s    = 16'h0000;
        reg_wr_data_s = 32'h0000_0000;
        reg_wr_en_s   = 1'b0;
        busy_s        = 1'b0;
        done_s        = done_r;
        error_s       = error_r;
        case (state_s)
            S_RD_A, S_RD_D: begin
                reg_addr_s = phase_addr(phase_s);
                busy_s     = 1'b1;
            end
            S_WR: begin
                reg_addr_s    = ADDR_CC;
                reg_wr_data_s = (phase_s == PH_ENA_WR) ? CC_ENA : 32'h0000_0000;
                reg_wr_en_s   = 1'b1;
                busy_s        = 1'b1;
            end
            S_GAP: begin
                busy_s = 1'b1;
            end
            S_FIN: begin
                done_s  = 1'b1;
                error_s = fin_err_s;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
        if (accept_s) begin
            done_s  = 1'b0;
            error_s = 2'd0;
        end else begin
            done_s  = done_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_addr_r    <= 16'h0000;
            reg_wr_data_r <= 32'h0000_0000;
            reg_wr_en_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 2'd0;
        end else begin
            reg_addr_r    <= reg_addr_s;
            reg_wr_data_r <= reg_wr_data_s;
            reg_wr_en_r   <= reg_wr_en_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            error_r       <= error_s;
        end
    end

    // CAP capture and timeout budget, latched at the end of each CAP data phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_r    <= 64'h0;
            budget_r <= 32'h0;
        end else if (state_r == S_RD_D && phase_r == PH_CAPL) begin
            cap_r[31:0] <= reg_rd_data;
            budget_r    <= 32'(({24'h00_0000, reg_rd_data[31:24]} + 32'd1) * TO_UNIT);
        end else if (state_r == S_RD_D && phase_r == PH_CAPH) begin
            cap_r[63:32] <= reg_rd_data;
        end else begin
            cap_r    <= cap_r;
            budget_r <= budget_r;
        end
    end

    // Poll-phase cycle counter (saturating) and inter-poll gap counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 32'h0;
            gap_r <= 32'h0;
        end else begin
            if (state_r == S_WR) begin
                cnt_r <= 32'h0;
            end else if (is_poll(phase_r) && state_r != S_IDLE && state_r != S_FIN) begin
                cnt_r <= (cnt_r == 32'hFFFF_FFFF) ? cnt_r : (cnt_r + 32'd1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == S_GAP) begin
                gap_r <= gap_r + 32'd1;
            end else begin
                gap_r <= 32'h0;
            end
        end
    end

    assign reg_addr    = reg_addr_r;
    assign reg_wr_data = reg_wr_data_r;
    assign reg_wr_en   = reg_wr_en_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign cap         = cap_r;

endmodule
